// File: rtl/eth_tx_sched_pkg.sv
// Shared constants and types for the eth_tx round-robin scheduler.
package eth_tx_sched_pkg;

   localparam int BYTE_LEN = 8;

   typedef enum logic [1:0] {
      ETH_TX_SCHED_IDLE   = 2'd0,
      ETH_TX_SCHED_START  = 2'd1,
      ETH_TX_SCHED_ACTIVE = 2'd2
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/eth_tx_sched_rr_pick.sv
// Combinational round-robin picker: first set bit at or above ptr_i,
// wrapping modulo N_REQ.
module eth_tx_sched_rr_pick
   import eth_tx_sched_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [N_REQ-1:0] win_o,
   output logic [IW-1:0]    idx_o
);

   logic [IW:0] j;
   logic        found;

   always_comb begin
      win_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = {1'b0, ptr_i} + (IW+1)'(k);
         if (j >= (IW+1)'(N_REQ))
            j = j - (IW+1)'(N_REQ);
         if (!found && req_i[j[IW-1:0]]) begin
            found              = 1'b1;
            win_o[j[IW-1:0]]   = 1'b1;
            idx_o              = j[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/eth_tx_sched.sv
// Round-robin scheduler sharing one eth_tx pipeline among N_REQ sources.
// Optional watchdog abort: define ETH_TX_SCHED_WATCHDOG_EN.
module eth_tx_sched
   import eth_tx_sched_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int CNT_WIDTH   = 16,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_inclk,
   input  logic [N_REQ*BYTE_LEN-1:0] req_in,
   input  logic [N_REQ-1:0]          req_in_done,
   output logic [N_REQ-1:0]          grant,
   output logic [N_REQ-1:0]          req_readclk,
   output logic                      tx_start,
   output logic                      tx_inclk,
   output logic [BYTE_LEN-1:0]       tx_in,
   output logic                      tx_in_done,
   input  logic                      tx_upstream_readclk,
   input  logic                      tx_done,
   output logic                      tx_abort,
   output logic                      busy,
   output logic [CNT_WIDTH-1:0]      frames_sent
);

   localparam int IW = idx_w(N_REQ);

   state_e               state_q, state_d;
   logic [N_REQ-1:0]     grant_q, grant_d;
   logic [IW-1:0]        gidx_q, gidx_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0] frames_q, frames_d;
   logic [N_REQ-1:0]     pick_oh;
   logic [IW-1:0]        pick_idx;
   logic                 wdog_hit;

   eth_tx_sched_rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .win_o (pick_oh),
      .idx_o (pick_idx)
   );

`ifdef ETH_TX_SCHED_WATCHDOG_EN
   localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

   logic [WW-1:0] wdog_q, wdog_d;

   // Cleared while starting, so it reads 0 on the first ACTIVE cycle.
   always_comb begin
      wdog_d = '0;
      if (state_q == ETH_TX_SCHED_ACTIVE)
         wdog_d = wdog_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         wdog_q <= '0;
      else
         wdog_q <= wdog_d;
   end

   assign wdog_hit = (state_q == ETH_TX_SCHED_ACTIVE) && !tx_done &&
                     (wdog_q == WW'(WDOG_CYCLES - 1));
`else
   assign wdog_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ETH_TX_SCHED_IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         ptr_q    <= '0;
         frames_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         gidx_q   <= gidx_d;
         ptr_q    <= ptr_d;
         frames_q <= frames_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      gidx_d   = gidx_q;
      ptr_d    = ptr_q;
      frames_d = frames_q;
      unique case (state_q)
         ETH_TX_SCHED_IDLE: begin
            if (|req) begin
               state_d = ETH_TX_SCHED_START;
               grant_d = pick_oh;
               gidx_d  = pick_idx;
            end
         end
         ETH_TX_SCHED_START: begin
            state_d = ETH_TX_SCHED_ACTIVE;
         end
         ETH_TX_SCHED_ACTIVE: begin
            if (tx_done || wdog_hit) begin
               state_d = ETH_TX_SCHED_IDLE;
               grant_d = '0;
               ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
               if (tx_done)
                  frames_d = frames_q + 1'b1;
            end
         end
         default: begin
            state_d = ETH_TX_SCHED_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      tx_start    = 1'b0;
      tx_inclk    = 1'b0;
      tx_in       = '0;
      tx_in_done  = 1'b0;
      req_readclk = '0;
      tx_abort    = 1'b0;
      busy        = 1'b1;
      unique case (state_q)
         ETH_TX_SCHED_IDLE: busy = 1'b0;
         ETH_TX_SCHED_START: tx_start = 1'b1;
         ETH_TX_SCHED_ACTIVE: begin
            tx_inclk    = req_inclk[gidx_q];
            tx_in       = req_in[int'(gidx_q)*BYTE_LEN +: BYTE_LEN];
            tx_in_done  = req_in_done[gidx_q];
            req_readclk = grant_q & {N_REQ{tx_upstream_readclk}};
            tx_abort    = wdog_hit;
         end
         default: busy = 1'b0;
      endcase
   end

   assign grant       = grant_q;
   assign frames_sent = frames_q;

endmodule
